// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard controller:
// FSM state encoding, forwarding select codes and register-address width.
package ex_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } haz_state_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// Operand forwarding comparator: chooses EX/MEM, MEM/WB or register-file data
// for one ALU source. The younger EX/MEM result wins; $0 is never forwarded.
module ex_hazard_ctrl_fwd_select
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    output logic [1:0]            sel_o
);

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
    assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

    always_comb begin
        sel_o = FWD_REG;
        if (exmem_hit) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ID/EX consumer-side hazard control: load-use stalls, taken-branch flushes and
// EX forwarding selects. Performance counters exist only with HAZ_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; detects taken branch / load-use hazard
// STALL | extra load-use hold cycles (cnt counts down to 0)
// FLUSH | extra wrong-path flush cycles after a taken branch
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1,
    parameter int BR_EXTRA = 0,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_mem_read_i,
    input  logic                  idex_branch_i,
    input  logic                  alu_zero_i,
    input  logic [REG_ADDR_W-1:0] idex_rs_i,
    input  logic [REG_ADDR_W-1:0] idex_rt_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs_i,
    input  logic [REG_ADDR_W-1:0] ifid_rt_i,
    input  logic                  ifid_uses_rt_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam logic [2:0] STALL_INIT = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
    localparam logic [2:0] FLUSH_INIT = (BR_EXTRA > 0) ? 3'(BR_EXTRA - 1) : 3'd0;

    haz_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic       taken;
    logic       lu_haz;
    logic       pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign taken  = idex_branch_i & alu_zero_i;
    assign lu_haz = idex_mem_read_i & (idex_rt_i != '0) &
                    ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        unique case (state_q)
            RUN: begin
                // A taken branch squashes the hazard instruction, so it wins.
                if (taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    if (BR_EXTRA > 0) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (lu_haz) begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_INIT;
                    end
                end
            end
            STALL: begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_bubble_c = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            FLUSH: begin
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    ex_hazard_ctrl_fwd_select u_fwd_a (
        .src_i             (idex_rs_i),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .sel_o             (fwd_a_c)
    );

    ex_hazard_ctrl_fwd_select u_fwd_b (
        .src_i             (idex_rt_i),
        .exmem_reg_write_i (exmem_reg_write_i),
        .exmem_rd_i        (exmem_rd_i),
        .memwb_reg_write_i (memwb_reg_write_i),
        .memwb_rd_i        (memwb_rd_i),
        .sel_o             (fwd_b_c)
    );

    // Reset holds the front end frozen and ID/EX bubbled without waiting for a clock.
    assign pc_write_o    = ~rst & pc_write_c;
    assign ifid_write_o  = ~rst & ifid_write_c;
    assign ifid_flush_o  = rst | ifid_flush_c;
    assign idex_bubble_o = rst | idex_bubble_c;
    assign fwd_a_o       = rst ? FWD_REG : fwd_a_c;
    assign fwd_b_o       = rst ? FWD_REG : fwd_b_c;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: three parameterisations share one stimulus
// stream; a cycle-count reference model predicts outputs, a monitor compares.
module tb_ex_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       br;
        logic       z;
        logic [4:0] xrs;
        logic [4:0] xrt;
        logic [4:0] frs;
        logic [4:0] frt;
        logic       uses_rt;
        logic       exw;
        logic [4:0] exrd;
        logic       mww;
        logic [4:0] mwrd;
    } stim_t;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        bub;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    localparam int LL [3] = '{1, 3, 4};
    localparam int BE [3] = '{0, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t s;
    logic [2:0]  pcw, ifw, fl, bub;
    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic [31:0] sc [3];
    logic [31:0] fc [3];

    exp_t [2:0] sb_q [$];
    int total = 0;
    int bad   = 0;

    int rem_st [3];
    int rem_fl [3];
    int m_sc   [3];
    int m_fc   [3];
    logic prev_rst;
    logic [2:0] prev_pcw, prev_fl;

    ex_hazard_ctrl #(.LOAD_LAT(1), .BR_EXTRA(0), .CNT_W(32)) u0 (
        .clk(clk), .rst(s.rst), .idex_mem_read_i(s.mr), .idex_branch_i(s.br), .alu_zero_i(s.z),
        .idex_rs_i(s.xrs), .idex_rt_i(s.xrt), .ifid_rs_i(s.frs), .ifid_rt_i(s.frt),
        .ifid_uses_rt_i(s.uses_rt), .exmem_reg_write_i(s.exw), .exmem_rd_i(s.exrd),
        .memwb_reg_write_i(s.mww), .memwb_rd_i(s.mwrd), .pc_write_o(pcw[0]), .ifid_write_o(ifw[0]),
        .ifid_flush_o(fl[0]), .idex_bubble_o(bub[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
        .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0]));

    ex_hazard_ctrl #(.LOAD_LAT(3), .BR_EXTRA(2), .CNT_W(32)) u1 (
        .clk(clk), .rst(s.rst), .idex_mem_read_i(s.mr), .idex_branch_i(s.br), .alu_zero_i(s.z),
        .idex_rs_i(s.xrs), .idex_rt_i(s.xrt), .ifid_rs_i(s.frs), .ifid_rt_i(s.frt),
        .ifid_uses_rt_i(s.uses_rt), .exmem_reg_write_i(s.exw), .exmem_rd_i(s.exrd),
        .memwb_reg_write_i(s.mww), .memwb_rd_i(s.mwrd), .pc_write_o(pcw[1]), .ifid_write_o(ifw[1]),
        .ifid_flush_o(fl[1]), .idex_bubble_o(bub[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
        .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1]));

    ex_hazard_ctrl #(.LOAD_LAT(4), .BR_EXTRA(1), .CNT_W(32)) u2 (
        .clk(clk), .rst(s.rst), .idex_mem_read_i(s.mr), .idex_branch_i(s.br), .alu_zero_i(s.z),
        .idex_rs_i(s.xrs), .idex_rt_i(s.xrt), .ifid_rs_i(s.frs), .ifid_rt_i(s.frt),
        .ifid_uses_rt_i(s.uses_rt), .exmem_reg_write_i(s.exw), .exmem_rd_i(s.exrd),
        .memwb_reg_write_i(s.mww), .memwb_rd_i(s.mwrd), .pc_write_o(pcw[2]), .ifid_write_o(ifw[2]),
        .ifid_flush_o(fl[2]), .idex_bubble_o(bub[2]), .fwd_a_o(fa[2]), .fwd_b_o(fb[2]),
        .stall_cnt_o(sc[2]), .flush_cnt_o(fc[2]));

    function automatic logic [1:0] ref_fwd(input stim_t t, input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (t.exw && t.exrd == src) return 2'b10;
        if (t.mww && t.mwrd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference: a hazard occupies a fixed number of cycles; while busy, new
    // events are ignored. Counters tally the cycles completed outside reset.
    task automatic predict_and_push(input stim_t t);
        exp_t [2:0] e;
        logic taken, luh;
        taken = t.br && t.z;
        luh   = t.mr && (t.xrt != 0) &&
                ((t.xrt == t.frs) || (t.uses_rt && t.xrt == t.frt));
        for (int i = 0; i < 3; i++) begin
            if (!prev_rst) begin
                if (!prev_pcw[i]) m_sc[i]++;
                if (prev_fl[i])   m_fc[i]++;
            end
            e[i].fa = t.rst ? 2'b00 : ref_fwd(t, t.xrs);
            e[i].fb = t.rst ? 2'b00 : ref_fwd(t, t.xrt);
            if (t.rst) begin
                rem_st[i] = 0; rem_fl[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b0011;
            end else if (rem_fl[i] > 0) begin
                rem_fl[i]--;
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b1111;
            end else if (rem_st[i] > 0) begin
                rem_st[i]--;
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b0001;
            end else if (taken) begin
                rem_fl[i] = BE[i];
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b1111;
            end else if (luh) begin
                rem_st[i] = LL[i] - 1;
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b0001;
            end else begin
                {e[i].pcw, e[i].ifw, e[i].fl, e[i].bub} = 4'b1100;
            end
`ifdef HAZ_PERF_CNT_EN
            e[i].sc = 32'(m_sc[i]);
            e[i].fc = 32'(m_fc[i]);
`else
            e[i].sc = 32'd0;
            e[i].fc = 32'd0;
`endif
            prev_pcw[i] = e[i].pcw;
            prev_fl[i]  = e[i].fl;
        end
        prev_rst = t.rst;
        sb_q.push_back(e);
    endtask

    task automatic drive(input stim_t t);
        @(posedge clk);
        #1;
        s = t;
        predict_and_push(t);
    endtask

    function automatic stim_t quiet();
        stim_t t;
        t = '0;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge.
    initial begin
        exp_t [2:0] e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    chk("pc_write",    i, 32'(pcw[i]), 32'(e[i].pcw));
                    chk("ifid_write",  i, 32'(ifw[i]), 32'(e[i].ifw));
                    chk("ifid_flush",  i, 32'(fl[i]),  32'(e[i].fl));
                    chk("idex_bubble", i, 32'(bub[i]), 32'(e[i].bub));
                    chk("fwd_a",       i, 32'(fa[i]),  32'(e[i].fa));
                    chk("fwd_b",       i, 32'(fb[i]),  32'(e[i].fb));
                    chk("stall_cnt",   i, sc[i],       e[i].sc);
                    chk("flush_cnt",   i, fc[i],       e[i].fc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t t;
        s = quiet();
        s.rst = 1'b1;
        prev_rst = 1'b1;
        prev_pcw = '0;
        prev_fl  = '1;
        for (int i = 0; i < 3; i++) begin
            rem_st[i] = 0; rem_fl[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
        t = quiet(); t.rst = 1'b1;
        drive(t);
        drive(t);
        drive(quiet());

        // load-use on r8, then idle long enough for the longest stall
        t = quiet(); t.mr = 1; t.xrt = 5'd8; t.frs = 5'd8;
        drive(t);
        repeat (5) drive(quiet());

        // taken branch together with a load-use hazard
        t.br = 1; t.z = 1;
        drive(t);
        repeat (4) drive(quiet());

        // forwarding priority and $0 handling
        t = quiet(); t.exw = 1; t.exrd = 5'd5; t.mww = 1; t.mwrd = 5'd5; t.xrs = 5'd5; t.xrt = 5'd5;
        drive(t);
        t.exrd = 5'd0;
        drive(t);
        t.xrs = 5'd0; t.xrt = 5'd0;
        drive(t);

        // $0 load never stalls
        t = quiet(); t.mr = 1; t.xrt = 5'd0; t.frs = 5'd0;
        drive(t);
        // rt-only hazard, gated by uses_rt
        t = quiet(); t.mr = 1; t.xrt = 5'd3; t.frt = 5'd3;
        drive(t);
        repeat (4) drive(quiet());
        t.uses_rt = 1;
        drive(t);
        repeat (4) drive(quiet());

        // reset during the second stall cycle
        t = quiet(); t.mr = 1; t.xrt = 5'd9; t.frs = 5'd9;
        drive(t);
        drive(quiet());
        t = quiet(); t.rst = 1;
        drive(t);
        repeat (3) drive(quiet());

        for (int n = 0; n < 400; n++) begin
            t.rst     = ($urandom_range(0, 59) == 0);
            t.mr      = ($urandom_range(0, 9) < 3);
            t.br      = ($urandom_range(0, 9) < 2);
            t.z       = $urandom_range(0, 1) != 0;
            t.xrs     = 5'($urandom_range(0, 3));
            t.xrt     = 5'($urandom_range(0, 3));
            t.frs     = 5'($urandom_range(0, 3));
            t.frt     = 5'($urandom_range(0, 3));
            t.uses_rt = $urandom_range(0, 1) != 0;
            t.exw     = $urandom_range(0, 1) != 0;
            t.exrd    = 5'($urandom_range(0, 3));
            t.mww     = $urandom_range(0, 1) != 0;
            t.mwrd    = 5'($urandom_range(0, 3));
            drive(t);
        end

        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
